// File: rtl/cordic_quadrant_restore.sv
// cordic_quadrant_restore: pops the folded-input sign tags and maps each first-quadrant CORDIC angle back to the full circle.
// Optional QRESTORE_ERR_EN adds a sticky tag_err for lost tags and orphan results.
module cordic_quadrant_restore #(
  parameter int DATA_WIDTH = 16,
  parameter int TAG_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tag_valid,
  input  logic                  tag_x_neg,
  input  logic                  tag_y_neg,
  output logic                  tag_ready,
  input  logic                  res_valid,
  input  logic [DATA_WIDTH-1:0] res_mag,
  input  logic [DATA_WIDTH-1:0] res_ang,
  output logic                  res_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_mag,
  output logic [DATA_WIDTH-1:0] out_ang,
  input  logic                  out_ready
`ifdef QRESTORE_ERR_EN
  ,
  output logic                  tag_err
`endif
);
  localparam int AW = $clog2(TAG_DEPTH);
  localparam logic [DATA_WIDTH-1:0] PI = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  logic [1:0] mem [TAG_DEPTH];
  logic [AW:0] wp, rp;
  logic full, empty, push, pop;
  logic [1:0] head;
  logic [DATA_WIDTH-1:0] ang;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign tag_ready = !full;
  assign res_ready = !empty && (!out_valid || out_ready);
  assign push = tag_valid && tag_ready;
  assign pop = res_valid && res_ready;
  assign head = mem[rp[AW-1:0]];
  // head = {x_neg, y_neg}
  assign ang = head[1] ? (head[0] ? res_ang - PI : PI - res_ang)
                       : (head[0] ? -res_ang : res_ang);
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= {tag_x_neg, tag_y_neg};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      out_valid <= 1'b0;
      out_mag <= '0;
      out_ang <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      if (pop) begin
        out_valid <= 1'b1;
        out_mag <= res_mag;
        out_ang <= ang;
      end else if (out_ready) out_valid <= 1'b0;
    end
`ifdef QRESTORE_ERR_EN
  localparam int CW = $clog2(TAG_DEPTH + 1);
  logic [CW-1:0] orphan;
  // orphan saturates at TAG_DEPTH; one more stalled cycle flags the error
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      orphan <= '0;
      tag_err <= 1'b0;
    end else begin
      orphan <= (res_valid && empty) ? (orphan == CW'(TAG_DEPTH) ? orphan : orphan + 1'b1) : '0;
      if ((tag_valid && full) || (res_valid && empty && orphan == CW'(TAG_DEPTH))) tag_err <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_cordic_quadrant_restore.sv
// tb_cordic_quadrant_restore: directed quadrant/full/stall/reset cases plus random traffic against a queue-based reference model.
module tb_cordic_quadrant_restore;
  logic clk = 0, rst_n = 0;
  logic tag_valid = 0, tag_x_neg = 0, tag_y_neg = 0, tag_ready;
  logic res_valid = 0, res_ready, out_valid, out_ready = 0;
  logic [15:0] res_mag = 0, res_ang = 0, out_mag, out_ang;
`ifdef QRESTORE_ERR_EN
  logic tag_err;
`endif
  int checks = 0, failures = 0;
  logic [1:0] tq[$];
  logic m_valid = 0, m_err = 0;
  logic [15:0] m_mag = 0, m_ang = 0;
  int orphan = 0;
  logic [15:0] qexp [4] = '{16'h2000, 16'h6000, 16'hA000, 16'hE000};

  cordic_quadrant_restore #(.DATA_WIDTH(16), .TAG_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .tag_valid(tag_valid), .tag_x_neg(tag_x_neg), .tag_y_neg(tag_y_neg), .tag_ready(tag_ready),
    .res_valid(res_valid), .res_mag(res_mag), .res_ang(res_ang), .res_ready(res_ready),
    .out_valid(out_valid), .out_mag(out_mag), .out_ang(out_ang), .out_ready(out_ready)
`ifdef QRESTORE_ERR_EN
    , .tag_err(tag_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Quadrant rule: reflect across the y axis when x<0, negate when y<0.
  function automatic logic [15:0] restore(input logic xn, input logic yn, input logic [15:0] a);
    int v;
    v = xn ? 32768 - int'(a) : int'(a);
    if (yn) v = -v;
    return 16'(v);
  endfunction

  task automatic step(input logic tv, input logic tx, input logic ty, input logic rv,
                      input logic [15:0] mg, input logic [15:0] an, input logic ordy);
    logic push, pop;
    logic [1:0] t;
    @(negedge clk);
    check("out_valid", out_valid, m_valid);
    if (m_valid) begin
      check("out_mag", out_mag, m_mag);
      check("out_ang", out_ang, m_ang);
    end
`ifdef QRESTORE_ERR_EN
    check("tag_err", tag_err, m_err);
`endif
    tag_valid = tv; tag_x_neg = tx; tag_y_neg = ty;
    res_valid = rv; res_mag = mg; res_ang = an; out_ready = ordy;
    #1;
    check("tag_ready", tag_ready, tq.size() < 4);
    check("res_ready", res_ready, tq.size() > 0 && (!m_valid || ordy));
    push = tv && tq.size() < 4;
    pop = rv && tq.size() > 0 && (!m_valid || ordy);
    if ((tv && tq.size() == 4) || (rv && tq.size() == 0 && orphan >= 4)) m_err = 1;
    orphan = (rv && tq.size() == 0) ? orphan + 1 : 0;
    @(posedge clk);
    if (pop) begin
      t = tq.pop_front();
      m_valid = 1; m_mag = mg; m_ang = restore(t[1], t[0], an);
    end else if (ordy) m_valid = 0;
    if (push) tq.push_back({tx, ty});
  endtask

  initial begin
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_mag", out_mag, 0);
    check("rst_out_ang", out_ang, 0);
    check("rst_tag_ready", tag_ready, 1);
    check("rst_res_ready", res_ready, 0);
    @(negedge clk); rst_n = 1;
    // Quadrant I single result
    step(1, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 16'h1234, 16'h2000, 1);
    #1;
    check("q1_valid", out_valid, 1);
    check("q1_mag", out_mag, 16'h1234);
    check("q1_ang", out_ang, 16'h2000);
    // All four quadrants queued, fifth tag held, then back-to-back results
    step(1, 0, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0, 1);
    step(1, 1, 1, 0, 0, 0, 1);
    step(1, 0, 1, 0, 0, 0, 1);
    #1 check("full_tag_ready", tag_ready, 0);
    step(1, 0, 0, 0, 0, 0, 1);
    tag_valid = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, 16'(16'h100 + i), 16'h2000, 1);
      #1 check("quad_ang", out_ang, qexp[i]);
    end
    // Empty stall: result waits until a tag shows up
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 16'h0042, 16'h0000, 1);
    step(1, 1, 0, 1, 16'h0042, 16'h0000, 1);
    step(0, 0, 0, 1, 16'h0042, 16'h0000, 1);
    #1 check("pi_ang", out_ang, 16'h8000);
    // Backpressure held output
    step(1, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 16'h0777, 16'h1000, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 16'h0777, 16'h1000, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    // Random traffic
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 99) < 55, 1'($urandom), 1'($urandom), $urandom_range(0, 99) < 55,
           16'($urandom), 16'($urandom_range(0, 16384)), $urandom_range(0, 99) < 65);
    // Reset mid-stream
    step(1, 1, 1, 0, 0, 0, 0);
    step(1, 0, 1, 1, 16'h0999, 16'h0100, 0);
    @(negedge clk);
    tag_valid = 0; res_valid = 0; rst_n = 0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_tag_ready", tag_ready, 1);
    check("mid_rst_mag", out_mag, 0);
    check("mid_rst_ang", out_ang, 0);
`ifdef QRESTORE_ERR_EN
    check("mid_rst_err", tag_err, 0);
`endif
    tq.delete(); m_valid = 0; m_mag = 0; m_ang = 0; m_err = 0; orphan = 0;
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 200; i++)
      step($urandom_range(0, 99) < 50, 1'($urandom), 1'($urandom), $urandom_range(0, 99) < 50,
           16'($urandom), 16'($urandom_range(0, 16384)), $urandom_range(0, 99) < 80);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
